// File: rtl/register_bank8.sv
// register_bank8: 8-entry x WIDTH-bit register bank (RAM8 storage stage).
//   - One synchronous write port (dmux8way-decoded enables), one combinational
//     read port (mux8way16 select), shared address.
//   - Bulk-clear sweeper FSM: rewrites every entry to CLR_VALUE, one per cycle,
//     with a registered busy / clr_done handshake.
// Build option: define REGISTER_BANK_BYPASS_EN for write-first reads; leave it
//   undefined for read-old behaviour. Storage, FSM and handshake are the same
//   in both builds.
module register_bank8 #(
  parameter int                 WIDTH     = 16,
  parameter logic [WIDTH-1:0]   CLR_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [2:0]       address,
  output logic [WIDTH-1:0] out,
  input  logic             clr_req,
  output logic             busy,
  output logic             clr_done
);

  // The read path is built on a 16-bit mux8way16; other widths are rejected.
  if (WIDTH != 16) begin : g_width_check
    $error("register_bank8: WIDTH must be 16 while built on mux8way16");
  end

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  // dmux8way: route a single enable to one of eight outputs.
  function automatic logic [7:0] dmux8way(input logic sel_in, input logic [2:0] sel);
    logic [7:0] dec;
    dec      = 8'b0000_0000;
    dec[sel] = sel_in;
    return dec;
  endfunction

  logic [WIDTH-1:0] mem_q [8];
  logic [WIDTH-1:0] mem_d [8];
  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       wr_sel;
  logic             wr_en;
  logic [WIDTH-1:0] rd_data;

  // Loads are only honoured while the sweeper is idle.
  assign wr_en  = load & ~busy_q;
  assign wr_sel = dmux8way(wr_en, address);

  // Next-state logic: user write, then sweep clear and FSM sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (wr_sel[i]) begin
        mem_d[i] = in;
      end else begin
        mem_d[i] = mem_q[i];
      end
    end

    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = SWEEP;
          cnt_d   = 3'd0;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      SWEEP: begin
        mem_d[cnt_q] = CLR_VALUE;
        cnt_d        = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          // Final entry cleared on this edge: hand back to IDLE and pulse done.
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = SWEEP;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers: storage, sweeper FSM and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        mem_q[i] <= CLR_VALUE;
      end
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        mem_q[i] <= mem_d[i];
      end
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // mux8way16: combinational select of the addressed entry.
  always_comb begin
    case (address)
      3'd0:    rd_data = mem_q[0];
      3'd1:    rd_data = mem_q[1];
      3'd2:    rd_data = mem_q[2];
      3'd3:    rd_data = mem_q[3];
      3'd4:    rd_data = mem_q[4];
      3'd5:    rd_data = mem_q[5];
      3'd6:    rd_data = mem_q[6];
      3'd7:    rd_data = mem_q[7];
      default: rd_data = CLR_VALUE;
    endcase
  end

`ifdef REGISTER_BANK_BYPASS_EN
  // Write-first: an accepted write always targets the read address, so one
  // extra mux_16 stage forwards the write data straight to the output.
  always_comb begin
    if (wr_en) begin
      out = in;
    end else begin
      out = rd_data;
    end
  end
`else
  // Read-old: the output shows stored contents until the write edge.
  always_comb begin
    out = rd_data;
  end
`endif

  assign busy     = busy_q;
  assign clr_done = done_q;

endmodule
